gpio_bus_arb: RTL and testbench

GPIO_BUS_ARB -- requirements
Module: gpio_bus_arb

---
 rtl/gpio_pkg.sv | 34 +++
 rtl/gpio_rr_arb.sv | 38 +++
 rtl/gpio_bus_arb.sv | 171 +++++++++++++++++
 tb/tb_gpio_bus_arb.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpio_pkg
// Brief    : Shared definitions for the GPIO bus arbiter: register offsets,
//            FSM state encoding and the address legality check.
// Revision : 1.0 - initial release
// ============================================================================
package gpio_pkg;

    // GPIO register offsets (word aligned, within the low 4 address bits)
    localparam logic [3:0] c_OFF_DATA  = 4'h0;
    localparam logic [3:0] c_OFF_DIR   = 4'h4;
    localparam logic [3:0] c_OFF_INPUT = 4'h8;

    // Arbiter FSM states, explicitly encoded
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } gpio_state_e;

    // An address is legal when everything above bit 3 is zero and the low
    // nibble hits one of the three register offsets. The caller reduces the
    // upper bits so this works for any address width.
    function automatic logic gpio_addr_legal(input logic i_upper_zero,
                                             input logic [3:0] i_low);
        return i_upper_zero &&
               ((i_low == c_OFF_DATA) || (i_low == c_OFF_DIR) ||
                (i_low == c_OFF_INPUT));
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : gpio_rr_arb
// Brief    : Combinational round-robin grant. Searches the request vector
//            starting at the priority pointer, ascending with wrap-around,
//            and returns a one-hot grant (all zero when nothing requests).
// Revision : 1.0 - initial release
// ============================================================================
module gpio_rr_arb #(
    parameter int NUM_REQ = 2,
    parameter int IW      = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_gnt
);

    int   w_ptr;
    logic w_found;

    // Walk offsets 0..NUM_REQ-1 from the pointer; first asserted request wins.
    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_ptr   = int'(i_ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && i_req[i] &&
                    ((w_ptr + k == i) || (w_ptr + k == i + NUM_REQ))) begin
                    o_gnt[i] = 1'b1;
                    w_found  = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gpio_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : gpio_bus_arb
// Brief    : Round-robin arbiter that lets NUM_REQ requesters share one GPIO
//            register port. One access in flight at a time:
//            IDLE (grant) -> ISSUE (strobe) -> [WAIT (read data)] -> RESP.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_bus_arb
    import gpio_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int AW      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ-1:0]    req_we_i,
    input  logic [NUM_REQ*AW-1:0] req_addr_i,
    input  logic [NUM_REQ*AW-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]    rsp_valid_o,
    output logic [AW-1:0]         rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [AW-1:0]         addr_o,
    output logic [AW-1:0]         wdata_o,
    output logic                  we_o,
    output logic                  re_o,
    input  logic [AW-1:0]         rdata_i,
    output logic                  busy_o
);

    localparam int IW = $clog2(NUM_REQ);

    gpio_state_e        r_state;
    gpio_state_e        w_next;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      r_owner;
    logic               r_we;
    logic               r_err;
    logic [AW-1:0]      r_addr;
    logic [AW-1:0]      r_wdata;
    logic [AW-1:0]      r_rdata;

    logic [NUM_REQ-1:0] w_gnt;
    logic               w_hs;
    logic               w_legal;
    logic [IW-1:0]      w_sel_idx;
    logic               w_sel_we;
    logic [AW-1:0]      w_sel_addr;
    logic [AW-1:0]      w_sel_wdata;

    gpio_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr_arb (
        .i_req (req_valid_i),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt)
    );

    // Ready is only ever the grant and only in IDLE, so this is the handshake.
    assign w_hs    = |(req_valid_i & req_ready_o);
    assign w_legal = gpio_addr_legal((r_addr >> 4) == '0, r_addr[3:0]);

    // Select the granted requester's command fields (grant is one-hot).
    always_comb begin
        w_sel_idx   = '0;
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_idx   = IW'(i);
                w_sel_we    = req_we_i[i];
                w_sel_addr  = req_addr_i[i*AW +: AW];
                w_sel_wdata = req_wdata_i[i*AW +: AW];
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: reads detour through WAIT for the GPIO read data.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = w_hs ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: w_next = (w_legal && !r_we) ? ST_WAIT : ST_RESP;
            ST_WAIT:  w_next = ST_RESP;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Capture the accepted command, advance the pointer, record error/read data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr   <= '0;
            r_owner <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_owner <= w_sel_idx;
                        r_we    <= w_sel_we;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_rdata <= '0;
                        r_err   <= 1'b0;
                        r_ptr   <= (w_sel_idx == IW'(NUM_REQ-1)) ? '0 : w_sel_idx + 1'b1;
                    end
                end
                ST_ISSUE: r_err   <= !w_legal;
                ST_WAIT:  r_rdata <= rdata_i;
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; everything is forced low while reset is held.
    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        rsp_rdata_o = '0;
        rsp_err_o   = 1'b0;
        addr_o      = '0;
        wdata_o     = '0;
        we_o        = 1'b0;
        re_o        = 1'b0;
        busy_o      = 1'b0;
        if (!rst_i) begin
            busy_o = (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: req_ready_o = w_gnt;
                ST_ISSUE: begin
                    if (w_legal) begin
                        addr_o  = r_addr;
                        wdata_o = r_wdata;
                        we_o    = r_we;
                        re_o    = !r_we;
                    end
                end
                ST_RESP: begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        rsp_valid_o[i] = (r_owner == IW'(i));
                    end
                    rsp_err_o = r_err;
                    if (!r_we && !r_err) begin
                        rsp_rdata_o = r_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gpio_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_bus_arb
// Brief    : Directed self-checking bench for gpio_bus_arb with a small GPIO
//            register model and a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_bus_arb;

    localparam int NUM_REQ = 2;
    localparam int AW      = 32;

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [NUM_REQ-1:0]    req_we;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*AW-1:0] req_wdata;
    logic [NUM_REQ-1:0]    rsp_valid_o;
    logic [AW-1:0]         rsp_rdata_o;
    logic                  rsp_err_o;
    logic [AW-1:0]         addr_o;
    logic [AW-1:0]         wdata_o;
    logic                  we_o;
    logic                  re_o;
    logic [AW-1:0]         rdata;
    logic                  busy_o;

    logic [AW-1:0] gpio_data;
    logic [AW-1:0] gpio_dir;
    logic [AW-1:0] gpio_in;

    typedef struct {
        int            owner;
        logic [AW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   glog[$];
    exp_t mon_e;
    int   tests;
    int   fails;

    gpio_bus_arb #(
        .NUM_REQ (NUM_REQ),
        .AW      (AW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .addr_o      (addr_o),
        .wdata_o     (wdata_o),
        .we_o        (we_o),
        .re_o        (re_o),
        .rdata_i     (rdata),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GPIO register model: writes land on the strobe edge, read data appears
    // in the cycle after re_o.
    always @(posedge clk) begin
        if (rst) begin
            gpio_data <= '0;
            gpio_dir  <= '0;
            rdata     <= '0;
        end else begin
            if (we_o) begin
                case (addr_o[3:0])
                    4'h0: gpio_data <= wdata_o;
                    4'h4: gpio_dir  <= wdata_o;
                    default: ;
                endcase
            end
            if (re_o) begin
                case (addr_o[3:0])
                    4'h0:    rdata <= gpio_data;
                    4'h4:    rdata <= gpio_dir;
                    4'h8:    rdata <= gpio_in;
                    default: rdata <= '0;
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor, sampled mid-low-phase: grant log, response scoreboard, idle bus.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready_o[i]) glog.push_back(i);
            end
            if (rsp_valid_o != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 64'(rsp_valid_o), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("rsp_owner", 64'(rsp_valid_o), 64'd1 << mon_e.owner);
                    check("rsp_rdata", 64'(rsp_rdata_o), 64'(mon_e.rdata));
                    check("rsp_err",   64'(rsp_err_o),   64'(mon_e.err));
                end
            end
            if (!we_o && !re_o) check("idle_bus", {addr_o, wdata_o}, 64'd0);
        end
    end

    // One full transaction from requester idx, with strobe and latency checks.
    task automatic xfer(input int idx, input logic we, input logic [AW-1:0] addr,
                        input logic [AW-1:0] wd, input logic [AW-1:0] exp_rd,
                        input logic exp_err);
        int n;
        req_valid[idx]              = 1'b1;
        req_we[idx]                 = we;
        req_addr[idx*AW +: AW]      = addr;
        req_wdata[idx*AW +: AW]     = wd;
        #1;
        n = 0;
        while (!req_ready_o[idx] && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check("grant_wait", 64'(n < 20), 64'd1);
        sb.push_back('{owner: idx, rdata: exp_rd, err: exp_err});
        @(negedge clk);                          // T+1
        req_valid[idx] = 1'b0;
        check("we_t1",    64'(we_o),    64'(we && !exp_err));
        check("re_t1",    64'(re_o),    64'(!we && !exp_err));
        check("addr_t1",  64'(addr_o),  exp_err ? 64'd0 : 64'(addr));
        check("wdata_t1", 64'(wdata_o), exp_err ? 64'd0 : 64'(wd));
        @(negedge clk);                          // T+2
        check("rsp_t2", 64'(rsp_valid_o), (we || exp_err) ? (64'd1 << idx) : 64'd0);
        if (!we && !exp_err) begin
            @(negedge clk);                      // T+3
            check("rsp_t3", 64'(rsp_valid_o), 64'd1 << idx);
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tests = 0; fails = 0;
        rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        gpio_in = 32'h5A;

        // Reset: all outputs low even with requests pending.
        repeat (2) @(negedge clk);
        req_valid = '1;
        #1;
        check("rst_ready",  64'(req_ready_o), 64'd0);
        check("rst_busy",   64'(busy_o), 64'd0);
        check("rst_rsp",    {rsp_valid_o, rsp_err_o, rsp_rdata_o}, 64'd0);
        check("rst_strobe", {we_o, re_o, addr_o}, 64'd0);
        check("rst_wdata",  64'(wdata_o), 64'd0);
        req_valid = '0;
        @(negedge clk); rst = 1'b0; #1;
        check("idle_busy", 64'(busy_o), 64'd0);
        @(negedge clk);

        // Basic write, read of INPUT, read-back of DATA and DIR.
        xfer(0, 1'b1, 32'h0, 32'hA5, 32'h0,  1'b0);
        xfer(1, 1'b0, 32'h8, 32'h0,  32'h5A, 1'b0);
        xfer(0, 1'b0, 32'h0, 32'h0,  32'hA5, 1'b0);
        xfer(1, 1'b1, 32'h4, 32'h3C, 32'h0,  1'b0);
        xfer(0, 1'b0, 32'h4, 32'h0,  32'h3C, 1'b0);

        // Illegal addresses: offset 0xC, upper bits set, misaligned.
        xfer(0, 1'b1, 32'hC,  32'h77, 32'h0, 1'b1);
        xfer(1, 1'b0, 32'h10, 32'h0,  32'h0, 1'b1);
        xfer(0, 1'b0, 32'h2,  32'h0,  32'h0, 1'b1);
        xfer(1, 1'b1, 32'h8000_0000, 32'h1, 32'h0, 1'b1);

        // Requester 1 arrives while requester 0's write is in flight.
        req_valid[0] = 1'b1; req_we[0] = 1'b1;
        req_addr[0 +: AW] = 32'h0; req_wdata[0 +: AW] = 32'h96;
        #1;
        check("busy_gnt0", 64'(req_ready_o), 64'd1);
        sb.push_back('{owner: 0, rdata: 32'h0,  err: 1'b0});
        sb.push_back('{owner: 1, rdata: 32'h96, err: 1'b0});
        @(negedge clk);
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[AW +: AW] = 32'h0;
        #1; check("busy_rdy1_t1", 64'(req_ready_o[1]), 64'd0);
        @(negedge clk); #1; check("busy_rdy1_t2", 64'(req_ready_o[1]), 64'd0);
        @(negedge clk); #1; check("busy_rdy1_t3", 64'(req_ready_o[1]), 64'd1);
        @(negedge clk); req_valid[1] = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during WAIT of a read aborts it and returns ptr to 0.
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0 +: AW] = 32'h8;
        #1;
        check("abort_gnt", 64'(req_ready_o), 64'd1);
        sb.push_back('{owner: 0, rdata: 32'h5A, err: 1'b0});
        @(negedge clk); req_valid[0] = 1'b0;
        check("abort_re", 64'(re_o), 64'd1);
        @(negedge clk);
        check("abort_busy_wait", 64'(busy_o), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        #1;
        check("abort_busy", 64'(busy_o), 64'd0);
        check("abort_rsp",  64'(rsp_valid_o), 64'd0);
        check("abort_re2",  64'(re_o), 64'd0);
        req_valid = '1; req_we = '0;
        req_addr = {32'h8, 32'h8};
        #1;
        check("abort_ptr0", 64'(req_ready_o), 64'd1);
        req_valid = '0;
        @(negedge clk);
        xfer(1, 1'b0, 32'h8, 32'h0, 32'h5A, 1'b0);

        // Both requesters valid continuously from reset: strict alternation.
        rst = 1'b1;
        req_valid = '1; req_we = '1;
        req_addr  = {32'h4, 32'h0};
        req_wdata = {32'h22, 32'h11};
        @(negedge clk);
        @(negedge clk);
        glog.delete();
        for (int i = 0; i < 4; i++) sb.push_back('{owner: i % 2, rdata: 32'h0, err: 1'b0});
        rst = 1'b0;
        n = 0;
        while (glog.size() < 4 && n < 40) begin
            @(negedge clk); #3;
            n++;
        end
        check("rr_wait", 64'(n < 40), 64'd1);
        @(negedge clk);
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            check("rr_order", (i < glog.size()) ? 64'(glog[i]) : 64'hFFFF, 64'(i % 2));
        end
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk); #3;
            n++;
        end
        repeat (2) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("final_data", 64'(gpio_dir), 64'h22);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
